// File: rtl/add_m_seq.sv
// Serial-load / serial-drain sequencer wrapped around an elementwise 3x3 add engine.
// Optional WAIT-state timeout is built only when ADD_M_SEQ_TIMEOUT_EN is defined.
module add_m_seq #(
  parameter int W       = 32,
  parameter int N       = 9,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           eng_start,
  input  logic           eng_busy,
  input  logic           eng_done,
  output logic [W*N-1:0] eng_a,
  output logic [W*N-1:0] eng_b,
  input  logic [W*N-1:0] eng_c,
  output logic           busy,
  output logic           err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    KICK,
    WAIT,
    DRAIN
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  w_idx_next;
  logic           r_run;
  logic           w_xfer;
  logic           w_last;
  logic           w_cap;
  logic           w_timeout;
  logic [W*N-1:0] w_c_flat;

  assign w_last    = (r_idx == IW'(N - 1));
  assign in_ready  = r_run && ((r_state == LOAD_A) || (r_state == LOAD_B));
  assign w_xfer    = in_valid && in_ready;
  assign w_cap     = (r_state == WAIT) && eng_done;
  assign eng_start = (r_state == KICK);
  assign out_valid = (r_state == DRAIN);
  assign out_data  = w_c_flat[W*r_idx +: W];
  assign busy      = !((r_state == LOAD_A) && (r_idx == '0));
  // eng_done takes priority over an expiring timeout on the same cycle.
  assign err       = w_timeout && !eng_done;

`ifdef ADD_M_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == KICK) begin
      r_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_timeout = (r_state == WAIT) && (r_cnt == CW'(TIMEOUT - 1));

  logic w_unused;
  assign w_unused = eng_busy;
`else
  assign w_timeout = 1'b0;

  logic w_unused;
  assign w_unused = eng_busy | (TIMEOUT < 0);
`endif

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD_A;
      r_idx   <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      LOAD_A: if (w_xfer) begin
        if (w_last) begin
          w_state_next = LOAD_B;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + IW'(1);
        end
      end
      LOAD_B: if (w_xfer) begin
        if (w_last) begin
          w_state_next = KICK;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + IW'(1);
        end
      end
      KICK: w_state_next = WAIT;
      WAIT: begin
        if (eng_done) begin
          w_state_next = DRAIN;
        end else if (w_timeout) begin
          w_state_next = LOAD_A;
          w_idx_next   = '0;
        end
      end
      DRAIN: if (out_ready) begin
        if (w_last) begin
          w_state_next = LOAD_A;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + IW'(1);
        end
      end
      default: begin
        w_state_next = LOAD_A;
        w_idx_next   = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elem
      logic [W-1:0] r_a;
      logic [W-1:0] r_b;
      logic [W-1:0] r_c;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_a <= '0;
          r_b <= '0;
          r_c <= '0;
        end else begin
          if (w_xfer && (r_idx == IW'(gi))) begin
            if (r_state == LOAD_A) r_a <= in_data;
            if (r_state == LOAD_B) r_b <= in_data;
          end
          if (w_cap) r_c <= eng_c[W*gi +: W];
        end
      end

      assign eng_a[W*gi +: W]    = r_a;
      assign eng_b[W*gi +: W]    = r_b;
      assign w_c_flat[W*gi +: W] = r_c;
    end
  endgenerate

endmodule

// File: tb/tb_add_m_seq.sv
// Directed bench for add_m_seq: engine model with fixed latency, scoreboard queue of
// expected sums filled at load time and drained as the sequencer emits results.
module tb_add_m_seq;

  localparam int W       = 32;
  localparam int N       = 9;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           eng_start;
  logic           eng_busy;
  logic           eng_done = 1'b0;
  logic [W*N-1:0] eng_a;
  logic [W*N-1:0] eng_b;
  logic [W*N-1:0] eng_c = '0;
  logic           busy;
  logic           err;

  always #5 clk = ~clk;

  add_m_seq #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eng_start (eng_start),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_c     (eng_c),
    .busy      (busy),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0;
  int start_cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int err_cyc = 0;
  bit eng_en = 1'b1;
  int eng_cnt = 0;

  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   sa[N];
  logic [W-1:0]   sb[N];
  logic [W*N-1:0] w_sum;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_start) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
    end
    if (out_valid) n_valid <= n_valid + 1;
    if (err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) w_sum[W*i +: W] = eng_a[W*i +: W] + eng_b[W*i +: W];
  end

  // Engine model: eng_done is visible LAT cycles after the eng_start cycle.
  assign eng_busy = (eng_cnt > 0);
  always @(negedge clk) begin
    if (eng_start) begin
      eng_cnt  <= LAT;
      eng_done <= 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt  <= eng_cnt - 1;
      eng_done <= (eng_cnt == 1) && eng_en;
      eng_c    <= w_sum;
    end else begin
      eng_done <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [W*N-1:0] obs, input logic [W*N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit gap);
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !in_ready; t++) tick();
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic load_txn(input bit gap);
    logic [W*N-1:0] pa;
    logic [W*N-1:0] pb;
    logic [W-1:0]   s;
    for (int i = 0; i < N; i++) send(sa[i], gap);
    for (int i = 0; i < N; i++) send(sb[i], gap);
    for (int i = 0; i < N; i++) begin
      pa[W*i +: W] = sa[i];
      pb[W*i +: W] = sb[i];
      s = sa[i] + sb[i];
      exp_q.push_back(s);
    end
    chk_wide("eng_a", eng_a, pa);
    chk_wide("eng_b", eng_b, pb);
  endtask

  task automatic drain(input int mode);
    int got = 0;
    bit hold = 1'b0;
    bit first = 1'b1;
    logic [W-1:0] prev = '0;
    logic [W-1:0] e;
    for (int t = 0; t < 400 && got < N; t++) begin
      out_ready = (mode == 1) ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      if (hold && out_valid) chk("out_hold", out_data, prev);
      if (out_valid && first) begin
        first = 1'b0;
        // DRAIN starts on the cycle after the engine's done cycle
        chk("latency", cyc - start_cyc, LAT + 1);
        chk("busy_drain", {31'b0, busy}, 32'd1);
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("out_data", out_data, e);
        got++;
      end
      hold = out_valid && !out_ready;
      prev = out_data;
      tick();
    end
    out_ready = 1'b1;
    chk("drain_count", got, N);
    chk("in_ready_after", {31'b0, in_ready}, 32'd1);
    chk("out_valid_after", {31'b0, out_valid}, 32'd0);
    chk("busy_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st0;
    int v0;
    int e0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    reset     = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_eng_start", {31'b0, eng_start}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk_wide("rst_eng_a", eng_a, '0);
    reset = 1'b1;
    #1;
    chk("in_ready_pre_edge", {31'b0, in_ready}, 32'd0);
    tick();
    chk("in_ready_post_edge", {31'b0, in_ready}, 32'd1);

    // Basic: A=1..9, B=9..1 -> all 10
    for (int i = 0; i < N; i++) begin sa[i] = W'(i + 1); sb[i] = W'(9 - i); end
    st0 = n_start;
    load_txn(1'b0);
    drain(0);
    chk("start_pulses_basic", n_start - st0, 1);

    // Input gaps: A=0..8, B=100..108
    for (int i = 0; i < N; i++) begin sa[i] = W'(i); sb[i] = W'(100 + i); end
    load_txn(1'b1);
    drain(0);

    // Backpressure 1,0,0,1
    for (int i = 0; i < N; i++) begin sa[i] = W'(32'h1000_0000 * i + 7); sb[i] = $urandom; end
    st0 = n_start;
    load_txn(1'b0);
    drain(1);
    chk("start_pulses_bp", n_start - st0, 1);

    // Back-to-back with wraparound, then A=B=1
    for (int i = 0; i < N; i++) begin sa[i] = 32'hFFFF_FFFF; sb[i] = 32'hFFFF_FFFF; end
    load_txn(1'b0);
    drain(0);
    for (int i = 0; i < N; i++) begin sa[i] = 32'd1; sb[i] = 32'd1; end
    load_txn(1'b0);
    drain(0);

    // Reset for 2 cycles while in WAIT
    for (int i = 0; i < N; i++) begin sa[i] = W'(50 + i); sb[i] = W'(7 * i); end
    load_txn(1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk_wide("midrst_eng_b", eng_b, '0);
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
    st0 = n_start;
    v0  = n_valid;
    repeat (10) tick();
    chk("midrst_no_start", n_start - st0, 0);
    chk("midrst_no_valid", n_valid - v0, 0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < N; i++) begin sa[i] = W'(3 * i); sb[i] = W'(1000 - i); end
    load_txn(1'b0);
    drain(0);

`ifdef ADD_M_SEQ_TIMEOUT_EN
    // Engine never finishes
    eng_en = 1'b0;
    e0 = n_err;
    v0 = n_valid;
    for (int i = 0; i < N; i++) begin sa[i] = W'(i); sb[i] = W'(i); end
    load_txn(1'b0);
    exp_q.delete();
    for (int t = 0; t < 300 && n_err == e0; t++) tick();
    chk("timeout_seen", n_err - e0, 1);
    chk("timeout_cycle", err_cyc - start_cyc, TIMEOUT);
    chk("timeout_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (LAT + 5) tick();
    chk("timeout_single_pulse", n_err - e0, 1);
    chk("timeout_no_valid", n_valid - v0, 0);
    eng_en = 1'b1;
`else
    e0 = 0;
    chk("err_never", n_err - e0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_m_seq.md
ADD_M_SEQ -- requirements
Module: add_m_seq

Interface
REQ-001 The block SHALL expose the following parameters:
- W, 32, element width in bits
- N, 9, elements per matrix (3x3, row-major, index 0..N-1)
- TIMEOUT, 64, WAIT-state cycle limit (used only with ADD_M_SEQ_TIMEOUT_EN)

REQ-002 The block SHALL expose the following ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_data  in  W  serial operand element
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data
- out_data  out  W  serial result element
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- eng_start  out  1  one-cycle start pulse to the add_m engine
- eng_busy  in  1  engine busy; monitored only, no effect on control
- eng_done  in  1  engine result valid
- eng_a  out  W*N  A buffer, flat; element i at bits [W*i+W-1:W*i]
- eng_b  out  W*N  B buffer, same packing as eng_a
- eng_c  in  W*N  engine result, same packing as eng_a
- busy  out  1  transaction in progress
- err  out  1  one-cycle timeout pulse

Function
REQ-003 The FSM SHALL have the states LOAD_A, LOAD_B, KICK, WAIT and DRAIN, with a shared index counter idx running 0..N-1.
REQ-004 In LOAD_A and LOAD_B, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-005 A transfer SHALL occur only when in_valid and in_ready are both 1; the element SHALL be written to A[idx] (LOAD_A) or B[idx] (LOAD_B), and idx SHALL then increment.
REQ-006 A transfer at idx=N-1 in LOAD_A SHALL move the FSM to LOAD_B with idx=0; a transfer at idx=N-1 in LOAD_B SHALL move it to KICK with idx=0.
REQ-007 Idle cycles on in_valid SHALL NOT change idx or any buffer contents.
REQ-008 eng_a and eng_b SHALL be driven continuously from the A and B buffers and SHALL remain stable from KICK until DRAIN exits.
REQ-009 In KICK, eng_start SHALL be 1 for exactly one cycle, after which the FSM SHALL enter WAIT unconditionally.
REQ-010 eng_done SHALL be sampled only in WAIT.
REQ-011 On the first WAIT cycle with eng_done=1, eng_c SHALL be captured into the C buffer and the FSM SHALL enter DRAIN on the next edge.
REQ-012 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal C[idx].
REQ-013 In DRAIN, when out_ready=0, out_data SHALL hold stable.
REQ-014 In DRAIN, each cycle with out_ready=1 SHALL increment idx.
REQ-015 An acceptance at idx=N-1 SHALL return the FSM to LOAD_A with idx=0 and out_valid=0 on the next cycle.
REQ-016 Minimum latency SHALL be 1 cycle (KICK) plus the engine latency plus 1 capture cycle from the last B transfer to the first out_valid.
REQ-017 Back-to-back transactions SHALL be supported: LOAD_A accepts data on the cycle immediately after the final DRAIN acceptance.
REQ-018 busy SHALL be 0 only in LOAD_A with idx=0, and 1 otherwise.
REQ-019 eng_busy SHALL NOT affect control.
REQ-020 Arithmetic SHALL be unchanged: elements pass through bit-exact with no truncation or extension.

Reset
REQ-021 While reset=0, the block SHALL asynchronously force: state LOAD_A, idx 0, A, B and C buffers all 0.
REQ-022 While reset=0, the block SHALL asynchronously force outputs: in_ready 0, out_valid 0, out_data 0, eng_start 0, eng_a 0, eng_b 0, busy 0, err 0.
REQ-023 After reset release, in_ready SHALL rise on the first clk edge, i.e. LOAD_A is active.
REQ-024 Reset asserted mid-transaction in any state SHALL abort it with no further eng_start and no out_valid; partially loaded data SHALL be discarded.

Configuration
REQ-025 With ADD_M_SEQ_TIMEOUT_EN defined, a cycle counter SHALL clear on KICK and increment each WAIT cycle.
REQ-026 With ADD_M_SEQ_TIMEOUT_EN defined, if TIMEOUT WAIT cycles elapse without eng_done, err SHALL pulse 1 for one cycle, the FSM SHALL return to LOAD_A with idx=0, the C buffer SHALL be left unchanged, and no out_valid SHALL be produced.
REQ-027 With ADD_M_SEQ_TIMEOUT_EN defined, if eng_done and timeout expiry coincide, eng_done SHALL win.
REQ-028 Without ADD_M_SEQ_TIMEOUT_EN, WAIT SHALL persist until eng_done, the err port SHALL remain present and tied to 0, and no counter logic SHALL be built.

Verification
REQ-029 Basic: A=1..9, B=9..1, engine model returns the elementwise sum after 3 cycles, out_ready=1 -> exactly one eng_start pulse, then nine outputs all equal to 10, then busy=0.
REQ-030 Input gaps: in_valid toggled 1/0 each cycle with A=0..8, B=100..108 -> outputs 100,102,...,116 in index order.
REQ-031 Backpressure: out_ready pattern 1,0,0,1 repeating during DRAIN -> no lost or duplicated element, and out_data holds while out_ready=0.
REQ-032 Back-to-back: two transactions, A=B=0xFFFFFFFF then A=B=1, engine wraps -> first 9 outputs 0xFFFFFFFE, next 9 outputs 2; in_ready=1 on the cycle after the 9th acceptance.
REQ-033 Reset mid-WAIT: reset=0 for 2 cycles while in WAIT, engine later asserts eng_done -> no out_valid, no eng_start; after reset release, a new transaction completes correctly.
REQ-034 Timeout (ADD_M_SEQ_TIMEOUT_EN defined, TIMEOUT=64): engine never asserts eng_done -> err=1 exactly 64 cycles after KICK, then in_ready=1 and out_valid never asserted.
